// File: rtl/spw_fifo_pkg.sv
// -----------------------------------------------------------------------------
// spw_fifo_pkg
// Shared constants for the SpaceWire N-Char FIFO.
//   DEF_DWIDTH : default word width (8 data bits + 1 control flag)
//   DEF_AWIDTH : default address width (64-entry FIFO)
//   fifo_depth : number of storage words for a given address width
// -----------------------------------------------------------------------------
package spw_fifo_pkg;

    localparam int unsigned DEF_DWIDTH = 9;
    localparam int unsigned DEF_AWIDTH = 6;

    function automatic int unsigned fifo_depth(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

endpackage

// File: rtl/spw_fifo_ram.sv
// -----------------------------------------------------------------------------
// spw_fifo_ram
// Simple dual-port storage for spw_fifo: one synchronous write port and one
// read port. The array has no reset, so synthesis can map it onto RAM
// primitives. The read data register lives in spw_fifo (data_out_q), which
// is where the resettable output register of the memory ends up.
//
// Ports
//   clock   : rising-edge clock
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address
//   rd_data : word stored at rd_addr
// -----------------------------------------------------------------------------
module spw_fifo_ram
    import spw_fifo_pkg::*;
#(
    parameter int unsigned DWIDTH = DEF_DWIDTH,
    parameter int unsigned AWIDTH = DEF_AWIDTH
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic [AWIDTH-1:0] rd_addr,
    output logic [DWIDTH-1:0] rd_data
);

    localparam int unsigned DEPTH = fifo_depth(AWIDTH);

    logic [DWIDTH-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/spw_fifo.sv
// -----------------------------------------------------------------------------
// spw_fifo
// Synchronous FIFO for SpaceWire N-Chars with registered status flags,
// occupancy count and one-cycle overflow/underflow pulses.
//
// Build option
//   SPW_FIFO_FWFT_EN : when defined, first-word fall-through: data_out shows
//                      the head word whenever the FIFO is not empty and
//                      data_valid = !empty. When undefined, data_out is
//                      registered and updates one cycle after an accepted
//                      read, with data_valid pulsing for that cycle.
//
// Ports
//   clock        : rising-edge clock
//   reset        : asynchronous active-low reset
//   wr_en        : write request (accepted when not full)
//   data_in      : write data
//   rd_en        : read request (accepted when not empty)
//   data_out     : read data
//   data_valid   : data_out carries a freshly read word
//   full, empty, almost_full, almost_empty : registered status flags
//   count        : stored words, 0..2**AWIDTH
//   overflow     : one-cycle pulse, write attempted while full
//   underflow    : one-cycle pulse, read attempted while empty
// -----------------------------------------------------------------------------
module spw_fifo
    import spw_fifo_pkg::*;
#(
    parameter int unsigned DWIDTH = DEF_DWIDTH,
    parameter int unsigned AWIDTH = DEF_AWIDTH,
    parameter int unsigned AF_LVL = 56,
    parameter int unsigned AE_LVL = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DWIDTH-1:0] data_in,
    input  logic              rd_en,
    output logic [DWIDTH-1:0] data_out,
    output logic              data_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [AWIDTH:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [AWIDTH:0] PTR_ONE = {{AWIDTH{1'b0}}, 1'b1};
    localparam logic [AWIDTH:0] AF_C    = AF_LVL[AWIDTH:0];
    localparam logic [AWIDTH:0] AE_C    = AE_LVL[AWIDTH:0];

    logic [AWIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [AWIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [AWIDTH:0]   count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              almost_full_q, almost_full_d;
    logic              almost_empty_q, almost_empty_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              wr_acc;
    logic              rd_acc;
    logic [DWIDTH-1:0] ram_rd_data;

    spw_fifo_ram #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) u_ram (
        .clock   (clock),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_q[AWIDTH-1:0]),
        .wr_data (data_in),
        .rd_addr (rd_ptr_q[AWIDTH-1:0]),
        .rd_data (ram_rd_data)
    );

    // Acceptance uses the registered flags only, so a read in the same cycle
    // never frees room for a write into a full FIFO (and vice versa).
    always_comb begin
        wr_acc         = wr_en && !full_q;
        rd_acc         = rd_en && !empty_q;
        wr_ptr_d       = wr_acc ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d       = rd_acc ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        // Modular difference of the extended pointers gives 0..2**AWIDTH.
        count_d        = wr_ptr_d - rd_ptr_d;
        empty_d        = (wr_ptr_d == rd_ptr_d);
        full_d         = (wr_ptr_d[AWIDTH-1:0] == rd_ptr_d[AWIDTH-1:0]) &&
                         (wr_ptr_d[AWIDTH] != rd_ptr_d[AWIDTH]);
        almost_full_d  = (count_d >= AF_C);
        almost_empty_d = (count_d <= AE_C);
        overflow_d     = wr_en && full_q;
        underflow_d    = rd_en && empty_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            full_q         <= full_d;
            empty_q        <= empty_d;
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
        end
    end

`ifdef SPW_FIFO_FWFT_EN
    // Head word is visible straight from storage; forced to zero while
    // empty so the output is defined after reset.
    assign data_out   = empty_q ? '0 : ram_rd_data;
    assign data_valid = !empty_q;
`else
    logic [DWIDTH-1:0] data_out_q, data_out_d;
    logic              data_valid_q, data_valid_d;

    always_comb begin
        data_out_d   = rd_acc ? ram_rd_data : data_out_q;
        data_valid_d = rd_acc;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
        end else begin
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
`endif

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_spw_fifo.sv
// -----------------------------------------------------------------------------
// tb_spw_fifo
// Directed, self-checking bench for spw_fifo (DWIDTH=9, AWIDTH=6, default
// registered-output build). A queue holds the words the FIFO should contain;
// each read pops the expected word and compares it with data_out one cycle
// later. Flags, count and error pulses are checked after every clock.
// -----------------------------------------------------------------------------
module tb_spw_fifo;

    localparam int DEPTH = 64;
    localparam int AFL   = 56;
    localparam int AEL   = 8;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [8:0] data_in;
    logic       rd_en;
    logic [8:0] data_out;
    logic       data_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [6:0] count;
    logic       overflow;
    logic       underflow;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] sb_q[$];
    logic [8:0] last_out;

    spw_fifo #(
        .DWIDTH (9),
        .AWIDTH (6),
        .AF_LVL (AFL),
        .AE_LVL (AEL)
    ) dut (
        .clock        (clk),
        .reset        (rst_n),
        .wr_en        (wr_en),
        .data_in      (data_in),
        .rd_en        (rd_en),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_status();
        int n;
        n = sb_q.size();
        chk("count",        count,        n);
        chk("full",         full,         (n == DEPTH));
        chk("empty",        empty,        (n == 0));
        chk("almost_full",  almost_full,  (n >= AFL));
        chk("almost_empty", almost_empty, (n <= AEL));
    endtask

    // One clock with the given requests; expectations come from the queue.
    task automatic cycle(input bit wr, input logic [8:0] din, input bit rd);
        bit         wacc, racc, ovf, unf;
        int         n;
        n       = sb_q.size();
        wacc    = wr && (n < DEPTH);
        racc    = rd && (n > 0);
        ovf     = wr && (n == DEPTH);
        unf     = rd && (n == 0);
        wr_en   = wr;
        data_in = din;
        rd_en   = rd;
        @(posedge clk);
        #1;
        if (racc) last_out = sb_q.pop_front();
        if (wacc) sb_q.push_back(din);
        $display("t=%0t wr=%0b din=%03h rd=%0b -> dout=%03h dv=%0b cnt=%0d full=%0b empty=%0b ovf=%0b unf=%0b",
                 $time, wr, din, rd, data_out, data_valid, count, full, empty, overflow, underflow);
        chk("data_valid", data_valid, racc);
        chk("data_out",   data_out,   last_out);
        chk("overflow",   overflow,   ovf);
        chk("underflow",  underflow,  unf);
        chk_status();
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        data_in  = '0;
        last_out = '0;

        // Reset state
        #12;
        chk("rst_data_out",   data_out,   9'h000);
        chk("rst_data_valid", data_valid, 1'b0);
        chk("rst_overflow",   overflow,   1'b0);
        chk("rst_underflow",  underflow,  1'b0);
        chk_status();
        @(negedge clk);
        rst_n = 1'b1;

        // Three writes then three reads, order and one-cycle latency
        cycle(1'b1, 9'h101, 1'b0);
        cycle(1'b1, 9'h0AA, 1'b0);
        cycle(1'b1, 9'h055, 1'b0);
        cycle(1'b0, 9'h000, 1'b1);
        cycle(1'b0, 9'h000, 1'b1);
        cycle(1'b0, 9'h000, 1'b1);
        chk("final_word", data_out, 9'h055);

        // Read while empty: underflow pulse, data_out held
        cycle(1'b0, 9'h000, 1'b1);
        cycle(1'b0, 9'h000, 1'b0);

        // Fill to 64, then a rejected 65th write
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 9'($urandom_range(0, 511)), 1'b0);
        chk("filled_count", count, 7'd64);
        cycle(1'b1, 9'h1FF, 1'b0);
        cycle(1'b0, 9'h000, 1'b0);

        // Full with both requests: only the read is taken
        cycle(1'b1, 9'h123, 1'b1);
        chk("full_both_count", count, 7'd63);

        // Drain to 30, then simultaneous read+write holds the count
        for (int i = 0; i < 33; i++) cycle(1'b0, 9'h000, 1'b1);
        cycle(1'b1, 9'h0F0, 1'b1);
        chk("both_at_30", count, 7'd30);
        while (sb_q.size() > 0) cycle(1'b0, 9'h000, 1'b1);
        cycle(1'b0, 9'h000, 1'b1);

        // Streaming 100 words through, crossing the address wrap
        cycle(1'b1, 9'($urandom_range(0, 511)), 1'b0);
        for (int i = 1; i < 100; i++) cycle(1'b1, 9'($urandom_range(0, 511)), 1'b1);
        cycle(1'b0, 9'h000, 1'b1);

        // Asynchronous reset with 20 words stored
        for (int i = 0; i < 20; i++) cycle(1'b1, 9'(i + 9'h040), 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        last_out = '0;
        chk("async_rst_count",      count,      7'd0);
        chk("async_rst_empty",      empty,      1'b1);
        chk("async_rst_full",       full,       1'b0);
        chk("async_rst_data_valid", data_valid, 1'b0);
        chk("async_rst_data_out",   data_out,   9'h000);
        @(negedge clk);
        rst_n = 1'b1;

        // Words stored before reset must be gone
        cycle(1'b1, 9'h1A5, 1'b0);
        cycle(1'b0, 9'h000, 1'b1);
        chk("post_rst_word", data_out, 9'h1A5);
        cycle(1'b0, 9'h000, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spw_fifo.md
SPW_FIFO -- requirements
Module: spw_fifo

Interface
REQ-001 SHALL have parameter DWIDTH, default 9, word width in bits (N-Char: 8 data + 1 control flag).
REQ-002 SHALL have parameter AWIDTH, default 6, address width; depth = 2**AWIDTH.
REQ-003 SHALL have parameter AF_LVL, default 56, almost_full asserts when count >= AF_LVL.
REQ-004 SHALL have parameter AE_LVL, default 8, almost_empty asserts when count <= AE_LVL.
REQ-005 SHALL have port: clock  in  1  single clock, rising edge.
REQ-006 SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port: wr_en  in  1  write request.
REQ-008 SHALL have port: data_in  in  DWIDTH  write data.
REQ-009 SHALL have port: rd_en  in  1  read request.
REQ-010 SHALL have port: data_out  out  DWIDTH  read data.
REQ-011 SHALL have port: data_valid  out  1  data_out holds a freshly read word.
REQ-012 SHALL have ports: full, empty, almost_full, almost_empty  out  1 each  status flags, registered.
REQ-013 SHALL have port: count  out  AWIDTH+1  stored words, 0..2**AWIDTH.
REQ-014 SHALL have ports: overflow, underflow  out  1 each  one-cycle error pulses.

Function
REQ-015 Write SHALL be accepted iff wr_en && !full; word stored at wr_ptr, wr_ptr increments.
REQ-016 Read SHALL be accepted iff rd_en && !empty; rd_ptr increments.
REQ-017 Pointers SHALL be AWIDTH+1 bits; low AWIDTH bits address storage; MSB is wrap bit; wrap from 2**AWIDTH-1 to 0 is silent.
REQ-018 empty SHALL be 1 when pointers are equal; full SHALL be 1 when addresses are equal and wrap bits differ.
REQ-019 Flags and count SHALL reflect accepted operations the cycle after the accepting edge.
REQ-020 Simultaneous accepted read and write SHALL leave count unchanged; when full, write is rejected even if a read is accepted that cycle; when empty, read is rejected even if a write is accepted that cycle.
REQ-021 wr_en while full SHALL pulse overflow for one cycle; data dropped, state unchanged.
REQ-022 rd_en while empty SHALL pulse underflow for one cycle; data_out unchanged, data_valid 0.
REQ-023 Default mode: data_out SHALL be registered, valid one cycle after the accepted read; data_valid high that cycle only; data_out holds its last value otherwise.

Reset
REQ-024 reset low SHALL asynchronously clear pointers, count, data_out, data_valid, overflow, underflow, full, almost_full; set empty=1 and almost_empty=1 (AE_LVL >= 0).
REQ-025 Storage array SHALL NOT be reset; contents after reset are don't-care and unreachable.
REQ-026 Reset asserted mid-transfer SHALL discard all stored words; first write after release lands at address 0.

Configuration
REQ-027 Macro SPW_FIFO_FWFT_EN defined: first-word fall-through; data_out SHALL present head word whenever !empty, data_valid = !empty, accepted read advances to next word same edge.
REQ-028 Macro SPW_FIFO_FWFT_EN undefined: behaviour per REQ-023.

Structure
REQ-029 Package spw_fifo_pkg SHALL hold default DWIDTH/AWIDTH constants and a depth helper function.
REQ-030 Storage SHALL be sub-module spw_fifo_ram: one write port, one read port, no reset, RAM-inferable.
REQ-031 Pointer/flag logic SHALL stay in spw_fifo.

Verification (DWIDTH=9, AWIDTH=6)
REQ-032 After reset, 3 writes 0x101,0x0AA,0x055 then 3 reads -> data_out 0x101,0x0AA,0x055, each 1 cycle after rd_en; empty=1 after.
REQ-033 64 writes -> full=1, count=64, almost_full from count 56; 65th write -> overflow pulse, count stays 64.
REQ-034 rd_en on empty -> underflow pulse, data_valid=0, data_out unchanged.
REQ-035 Full FIFO, simultaneous wr_en+rd_en -> read accepted, write rejected, count=63; at count 30 both -> count stays 30.
REQ-036 Write 100 then read 100 words continuously -> order preserved across address wrap 63->0.
REQ-037 Reset asserted with count=20 -> empty=1, count=0 immediately, before next clock edge; FWFT build: first write shows on data_out with data_valid next cycle.
